// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the multicycle MIPS controller:
//                state encodings for the main decoder FSM, the supported
//                opcode values, the bundled control-word type and a helper
//                that classifies an opcode as supported or not.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Main decoder states. The numeric values are visible on the debug
    // state port, so they are fixed and must not be re-ordered.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    // Opcode field values (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU-B mux selects.
    localparam logic [1:0] ALUB_RD2    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

    // PC mux selects.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Codes handed to aludec.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // All state-derived datapath controls in one word so a state can start
    // from "everything off" and name only what it drives.
    typedef struct packed {
        logic       pcwrite;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       branch;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // True for the six opcodes this controller executes.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/maindec.sv
`default_nettype none
// ============================================================================
//  Module      : maindec
//  Description : Main decoder of the multicycle MIPS controller. A Moore FSM
//                that sequences FETCH/DECODE and the per-instruction execute
//                and write-back steps, driving datapath enables and selects
//                from the current state only.
//  Ports       : clk, reset (sync, active high)
//                op[5:0]            opcode from the instruction register
//                pcwrite, memwrite, irwrite, regwrite   write enables
//                alusrca, branch, iord, memtoreg, regdst mux selects/qualifier
//                alusrcb[1:0], pcsrc[1:0], aluop[1:0]     multi-bit selects
//                state[3:0]          current state (debug)
//                illegal             unsupported op seen in DECODE
//  Revision    : 1.0  initial release
// ============================================================================
module maindec
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       illegal
);

    state_e state_q;
    state_e state_d;
    ctrl_t  w_ctrl;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. op is only consulted in DECODE and MEMADR, so the
    // instruction register may change freely elsewhere.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_RTYPEEX;
                    OP_BEQ:   state_d = S_BEQEX;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JEX;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Anything other than LW/SW here means the opcode changed
                // under us; returning to FETCH avoids a spurious access.
                case (op)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
            end
            S_RTYPEEX: begin
                state_d = S_RTYPEWB;
            end
            S_ADDIEX: begin
                state_d = S_ADDIWB;
            end
            S_MEMWB, S_MEMWR, S_RTYPEWB,
            S_BEQEX, S_ADDIWB, S_JEX: begin
                state_d = S_FETCH;
            end
            // Encodings 12-15 recover to FETCH on the next edge.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode. Every state starts from all-zero controls.
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl = CTRL_NONE;
        case (state_q)
            S_FETCH: begin
                w_ctrl.alusrcb = ALUB_FOUR;
                w_ctrl.aluop   = ALUOP_ADD;
                w_ctrl.pcsrc   = PCSRC_ALU;
                w_ctrl.irwrite = 1'b1;
                w_ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target into aluout.
                w_ctrl.alusrcb = ALUB_IMMSH2;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUB_IMM;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctrl.iord = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.memwrite = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            S_RTYPEEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUB_RD2;
                w_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                w_ctrl.regdst   = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUB_RD2;
                w_ctrl.aluop   = ALUOP_SUB;
                w_ctrl.pcsrc   = PCSRC_ALUOUT;
                w_ctrl.branch  = 1'b1;
            end
            S_ADDIWB: begin
                w_ctrl.regwrite = 1'b1;
            end
            S_JEX: begin
                w_ctrl.pcsrc   = PCSRC_JUMP;
                w_ctrl.pcwrite = 1'b1;
            end
            default: begin
                w_ctrl = CTRL_NONE;
            end
        endcase
    end

    assign pcwrite  = w_ctrl.pcwrite;
    assign memwrite = w_ctrl.memwrite;
    assign irwrite  = w_ctrl.irwrite;
    assign regwrite = w_ctrl.regwrite;
    assign alusrca  = w_ctrl.alusrca;
    assign branch   = w_ctrl.branch;
    assign iord     = w_ctrl.iord;
    assign memtoreg = w_ctrl.memtoreg;
    assign regdst   = w_ctrl.regdst;
    assign alusrcb  = w_ctrl.alusrcb;
    assign pcsrc    = w_ctrl.pcsrc;
    assign aluop    = w_ctrl.aluop;
    assign state    = state_q;

    // The only output that looks at op directly (Mealy-style flag).
    assign illegal  = (state_q == S_DECODE) && !op_supported(op);

endmodule : maindec
`default_nettype wire

// File: tb/tb_maindec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maindec
//  Description : Self-checking bench for maindec. Directed instruction runs
//                followed by randomized opcode/reset traffic, compared each
//                cycle against an instruction-level reference model (path
//                queue per instruction class, control table per state and
//                instruction latency table).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maindec;
    import mips_pkg::*;

    localparam int C_RAND_CYCLES = 3000;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       pcwrite, memwrite, irwrite, regwrite;
    logic       alusrca, branch, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;
    logic       illegal;

    int n_vec;
    int n_err;

    // Reference model state
    int m_state;
    int m_path[$];
    int lat_exp;
    bit lat_pend;
    int lat_cnt;

    maindec u_dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .pcwrite  (pcwrite),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .branch   (branch),
        .iord     (iord),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .state    (state),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word per state, packed as
    // {pcwrite,memwrite,irwrite,regwrite,alusrca,branch,iord,memtoreg,regdst,
    //  alusrcb[1:0],pcsrc[1:0],aluop[1:0]}
    function automatic logic [14:0] exp_ctrl(input int s);
        logic pw, mw, iw, rw, sa, br, io, mr, rd;
        logic [1:0] sb, ps, ao;
        {pw, mw, iw, rw, sa, br, io, mr, rd} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (s)
            0:  begin sb = 2'b01; iw = 1'b1; pw = 1'b1; end
            1:  begin sb = 2'b11; end
            2,
            9:  begin sa = 1'b1; sb = 2'b10; end
            3:  begin io = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            4:  begin mr = 1'b1; rw = 1'b1; end
            6:  begin sa = 1'b1; ao = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
            10: begin rw = 1'b1; end
            11: begin ps = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        return {pw, mw, iw, rw, sa, br, io, mr, rd, sb, ps, ao};
    endfunction

    function automatic bit is_known_op(input logic [5:0] o);
        return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    // Instruction latency from FETCH entry back to FETCH.
    function automatic int op_latency(input logic [5:0] o);
        case (o)
            6'b100011:                      return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:           return 3;
            default:                        return 2;
        endcase
    endfunction

    // One clock: apply inputs, advance the model, then check the DUT.
    task automatic step(input logic rst_v, input logic [5:0] op_v);
        int nxt;
        reset = rst_v;
        op    = op_v;
        if (rst_v) begin
            m_path.delete();
            nxt = 0;
        end else begin
            if (m_state == 1) begin
                m_path.delete();
                case (op_v)
                    6'b100011, 6'b101011: m_path = '{2};
                    6'b000000:            m_path = '{6, 7};
                    6'b000100:            m_path = '{8};
                    6'b001000:            m_path = '{9, 10};
                    6'b000010:            m_path = '{11};
                    default:              m_path.delete();
                endcase
                lat_exp  = op_latency(op_v);
                lat_pend = 1'b1;
            end else if (m_state == 2) begin
                m_path.delete();
                if (op_v == 6'b100011) m_path = '{3, 4};
                else if (op_v == 6'b101011) m_path = '{5};
                lat_exp = op_latency(op_v);
            end
            if (m_state == 0)            nxt = 1;
            else if (m_path.size() > 0)  nxt = m_path.pop_front();
            else                         nxt = 0;
        end
        @(posedge clk);
        #1;
        m_state = nxt;
        check("state", {28'd0, state}, nxt);
        check("ctrl", {17'd0, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
                       iord, memtoreg, regdst, alusrcb, pcsrc, aluop},
              {17'd0, exp_ctrl(nxt)});
        check("illegal", {31'd0, illegal}, {31'd0, (nxt == 1) && !is_known_op(op_v)});
        // Latency measured on the DUT's own state sequence.
        if (state == 4'd0) begin
            if (lat_pend && !rst_v) check("latency", lat_cnt + 1, lat_exp);
            lat_pend = 1'b0;
            lat_cnt  = 0;
        end else begin
            lat_cnt++;
        end
    endtask

    task automatic run_instr(input logic [5:0] o);
        // From FETCH: FETCH->DECODE, then until back in FETCH.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, o);
            if (m_state == 0) break;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_state = 0; lat_exp = 0; lat_pend = 1'b0; lat_cnt = 0;
        reset = 1'b1;
        op    = 6'h23;

        // Reset held two cycles with LW on op.
        step(1'b1, 6'h23);
        step(1'b1, 6'h23);
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_alusrcb", {30'd0, alusrcb}, 32'd1);

        // LW: 0,1,2,3,4,0
        run_instr(6'b100011);
        // BEQ then J
        run_instr(6'b000100);
        run_instr(6'b000010);
        // Illegal op
        run_instr(6'b111111);
        // SW with reset asserted in MEMWR
        step(1'b0, 6'b101011);
        step(1'b0, 6'b101011);
        step(1'b0, 6'b101011);
        check("sw_in_memwr", {28'd0, state}, 32'd5);
        step(1'b1, 6'b101011);
        check("abort_memwrite", {31'd0, memwrite}, 32'd0);
        // ADDI with op toggled in ADDIEX
        step(1'b0, 6'b001000);
        step(1'b0, 6'b001000);
        check("addiex_alusrcb", {30'd0, alusrcb}, 32'd2);
        step(1'b0, 6'b000000);
        step(1'b0, 6'b000000);
        // R-type and a plain SW
        run_instr(6'b000000);
        run_instr(6'b101011);

        // Randomized traffic; op may change every cycle.
        for (int i = 0; i < C_RAND_CYCLES; i++) begin
            logic [5:0] o;
            logic       r;
            case ($urandom_range(0, 7))
                0: o = 6'b000000;
                1: o = 6'b100011;
                2: o = 6'b101011;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                default: o = 6'($urandom);
            endcase
            if (m_state == 2) o = ($urandom_range(0, 1) == 0) ? 6'b100011 : 6'b101011;
            r = ($urandom_range(0, 63) == 0);
            step(r, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_maindec
`default_nettype wire
